// File: rtl/pipe_fsm_pkg.sv
// Shared codes and helpers for the wall-follower pipeline controller.
// Turn/action/heading/command encodings plus location stepping.
package pipe_fsm_pkg;

  typedef enum logic [0:0] {
    ST_OFF = 1'b0,
    ST_ON  = 1'b1
  } state_e;

  localparam logic [1:0] TURN_STRAIGHT = 2'b00;
  localparam logic [1:0] TURN_RIGHT    = 2'b01;
  localparam logic [1:0] TURN_LEFT     = 2'b10;
  localparam logic [1:0] TURN_UTURN    = 2'b11;

  localparam logic [2:0] ACT_NONE  = 3'b000;
  localparam logic [2:0] ACT_M0    = 3'b001;
  localparam logic [2:0] ACT_M1    = 3'b010;
  localparam logic [2:0] ACT_M2    = 3'b011;
  localparam logic [2:0] ACT_M3    = 3'b100;
  localparam logic [2:0] ACT_FAULT = 3'b110;
  localparam logic [2:0] ACT_STOP  = 3'b111;

  localparam logic [3:0] HDG_N = 4'b1000;
  localparam logic [3:0] HDG_E = 4'b0100;
  localparam logic [3:0] HDG_S = 4'b0010;
  localparam logic [3:0] HDG_W = 4'b0001;

  localparam logic [1:0] CMD_START = 2'b01;
  localparam logic [1:0] CMD_STOP  = 2'b10;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Row and column wrap independently; no carry between nibbles.
  function automatic logic [7:0] step_loc(input logic [7:0] loc, input logic [3:0] hdg);
    logic [3:0] row;
    logic [3:0] col;
    row = loc[7:4];
    col = loc[3:0];
    case (hdg)
      HDG_N:   row = row - 4'd1;
      HDG_S:   row = row + 4'd1;
      HDG_E:   col = col + 4'd1;
      HDG_W:   col = col - 4'd1;
      default: row = loc[7:4];
    endcase
    return {row, col};
  endfunction

endpackage

// File: rtl/pipe_fsm_decide.sv
// Combinational right-hand-rule decision: walls + heading + maintenance flags
// to turn, new heading, action and compass fault.
module pipe_fsm_decide
  import pipe_fsm_pkg::*;
(
  input  logic [2:0] wll,
  input  logic [3:0] cmps,
  input  logic [3:0] mtn,
  output logic [1:0] turn,
  output logic [3:0] heading,
  output logic [2:0] action,
  output logic       fault
);

  logic [1:0] turn_raw_s;
  logic [3:0] heading_raw_s;
  logic [2:0] action_raw_s;

  // Raw decision, then a bad compass overrides everything.
  always_comb begin
    turn_raw_s    = TURN_UTURN;
    heading_raw_s = cmps;
    action_raw_s  = ACT_NONE;
    fault         = !is_onehot(cmps);

    if (!wll[0]) begin
      turn_raw_s = TURN_RIGHT;
    end else if (!wll[1]) begin
      turn_raw_s = TURN_STRAIGHT;
    end else if (!wll[2]) begin
      turn_raw_s = TURN_LEFT;
    end else begin
      turn_raw_s = TURN_UTURN;
    end

    case (turn_raw_s)
      TURN_RIGHT: heading_raw_s = {cmps[0], cmps[3:1]};
      TURN_LEFT:  heading_raw_s = {cmps[2:0], cmps[3]};
      TURN_UTURN: heading_raw_s = {cmps[1:0], cmps[3:2]};
      default:    heading_raw_s = cmps;
    endcase

    if (mtn[3]) begin
      action_raw_s = ACT_M3;
    end else if (mtn[2]) begin
      action_raw_s = ACT_M2;
    end else if (mtn[1]) begin
      action_raw_s = ACT_M1;
    end else if (mtn[0]) begin
      action_raw_s = ACT_M0;
    end else begin
      action_raw_s = ACT_NONE;
    end

    if (fault) begin
      turn    = TURN_STRAIGHT;
      heading = cmps;
      action  = ACT_FAULT;
    end else begin
      turn    = turn_raw_s;
      heading = heading_raw_s;
      action  = action_raw_s;
    end
  end

endmodule

// File: rtl/pipe_fsm.sv
// Three-stage wall-follower controller: sample on strobe, decide, then move.
// ON/OFF commands override any strobe seen on the same edge.
module pipe_fsm
  import pipe_fsm_pkg::*;
(
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [1:0] ONOFF,
  input  logic [7:0] LCN_0,
  input  logic [3:0] MTN_SENSOR,
  input  logic [3:0] CMPS,
  input  logic [3:0] WLL,
  output logic [1:0] TURN,
  output logic       DRIVING,
  output logic [7:0] LOCATION,
  output logic [2:0] ACTION
);

  state_e     state_r;
  state_e     state_next_s;
  logic       cmd_start_s;
  logic       cmd_stop_s;
  logic       strobe_s;
  logic [2:0] wll_prev_r;

  logic       s1_valid_r;
  logic [2:0] s1_wll_r;
  logic [3:0] s1_cmps_r;
  logic [3:0] s1_mtn_r;
  logic       s2_move_r;
  logic [3:0] s2_heading_r;

  logic [1:0] dec_turn_s;
  logic [3:0] dec_heading_s;
  logic [2:0] dec_action_s;
  logic       dec_fault_s;

  logic       unused_wll_s;
  assign unused_wll_s = WLL[3];

  pipe_fsm_decide u_decide (
    .wll     (s1_wll_r),
    .cmps    (s1_cmps_r),
    .mtn     (s1_mtn_r),
    .turn    (dec_turn_s),
    .heading (dec_heading_s),
    .action  (dec_action_s),
    .fault   (dec_fault_s)
  );

  // Command decode, rising-edge strobe detect and next state.
  always_comb begin
    cmd_start_s  = (ONOFF == CMD_START);
    cmd_stop_s   = (ONOFF == CMD_STOP);
    strobe_s     = (state_r == ST_ON) && (WLL[2:0] != 3'd0) && (wll_prev_r == 3'd0)
                   && !cmd_start_s && !cmd_stop_s;
    state_next_s = state_r;
    if (cmd_start_s) begin
      state_next_s = ST_ON;
    end else if (cmd_stop_s) begin
      state_next_s = ST_OFF;
    end else begin
      state_next_s = state_r;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= ST_OFF;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Pipeline stages and registered outputs.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      wll_prev_r   <= 3'd0;
      s1_valid_r   <= 1'b0;
      s1_wll_r     <= 3'd0;
      s1_cmps_r    <= 4'd0;
      s1_mtn_r     <= 4'd0;
      s2_move_r    <= 1'b0;
      s2_heading_r <= 4'd0;
      TURN         <= TURN_STRAIGHT;
      DRIVING      <= 1'b0;
      LOCATION     <= 8'd0;
      ACTION       <= ACT_NONE;
    end else begin
      wll_prev_r   <= WLL[2:0];
      s1_wll_r     <= WLL[2:0];
      s1_cmps_r    <= CMPS;
      s1_mtn_r     <= MTN_SENSOR;
      s2_heading_r <= dec_heading_s;
      if (cmd_start_s || cmd_stop_s) begin
        s1_valid_r <= 1'b0;
        s2_move_r  <= 1'b0;
        TURN       <= TURN_STRAIGHT;
        DRIVING    <= 1'b0;
        ACTION     <= cmd_start_s ? ACT_NONE : ACT_STOP;
        LOCATION   <= cmd_start_s ? LCN_0 : LOCATION;
      end else begin
        s1_valid_r <= strobe_s;
        s2_move_r  <= s1_valid_r && !dec_fault_s;
        if (s1_valid_r) begin
          TURN    <= dec_turn_s;
          ACTION  <= dec_action_s;
          DRIVING <= !dec_fault_s;
        end else begin
          TURN    <= TURN;
          ACTION  <= ACTION;
          DRIVING <= DRIVING;
        end
        LOCATION <= s2_move_r ? step_loc(LOCATION, s2_heading_r) : LOCATION;
      end
    end
  end

endmodule

// File: tb/tb_pipe_fsm.sv
// Scoreboard bench for pipe_fsm: expected decisions/locations are queued
// with their due cycle and compared by a negedge monitor.
module tb_pipe_fsm;

  logic       CLK;
  logic       RST_N;
  logic [1:0] ONOFF;
  logic [7:0] LCN_0;
  logic [3:0] MTN_SENSOR;
  logic [3:0] CMPS;
  logic [3:0] WLL;
  logic [1:0] TURN;
  logic       DRIVING;
  logic [7:0] LOCATION;
  logic [2:0] ACTION;

  pipe_fsm dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .ONOFF      (ONOFF),
    .LCN_0      (LCN_0),
    .MTN_SENSOR (MTN_SENSOR),
    .CMPS       (CMPS),
    .WLL        (WLL),
    .TURN       (TURN),
    .DRIVING    (DRIVING),
    .LOCATION   (LOCATION),
    .ACTION     (ACTION)
  );

  typedef struct {
    int         due;
    bit         is_loc;
    logic [1:0] turn;
    logic [2:0] act;
    logic       drv;
    logic [7:0] loc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_loc = 8'h00;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard monitor: compare entries whose due cycle has arrived.
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].due == cyc) begin
      mon_e = sb.pop_front();
      if (mon_e.is_loc) begin
        check_val("sb_location", {24'd0, LOCATION}, {24'd0, mon_e.loc});
      end else begin
        check_val("sb_turn", {30'd0, TURN}, {30'd0, mon_e.turn});
        check_val("sb_action", {29'd0, ACTION}, {29'd0, mon_e.act});
        check_val("sb_driving", {31'd0, DRIVING}, {31'd0, mon_e.drv});
      end
    end
  end

  // Independent reference: directions indexed N=0,E=1,S=2,W=3.
  task automatic issue(input logic [3:0] w, input logic [3:0] c, input logic [3:0] m, input int hold);
    exp_t       d;
    exp_t       l;
    int         dir;
    int         delta;
    logic [3:0] row;
    logic [3:0] col;
    d.due = cyc + 2; d.is_loc = 1'b0; d.loc = 8'h00;
    l.due = cyc + 3; l.is_loc = 1'b1; l.turn = 2'b00; l.act = 3'b000; l.drv = 1'b0;
    if ($countones(c) != 1) begin
      d.turn = 2'b00; d.act = 3'b110; d.drv = 1'b0;
    end else begin
      if (w[0] == 1'b0)      begin d.turn = 2'b01; delta = 1; end
      else if (w[1] == 1'b0) begin d.turn = 2'b00; delta = 0; end
      else if (w[2] == 1'b0) begin d.turn = 2'b10; delta = 3; end
      else                   begin d.turn = 2'b11; delta = 2; end
      if (m[3])      d.act = 3'b100;
      else if (m[2]) d.act = 3'b011;
      else if (m[1]) d.act = 3'b010;
      else if (m[0]) d.act = 3'b001;
      else           d.act = 3'b000;
      d.drv = 1'b1;
      dir = c[3] ? 0 : c[2] ? 1 : c[1] ? 2 : 3;
      dir = (dir + delta) % 4;
      row = exp_loc[7:4];
      col = exp_loc[3:0];
      case (dir)
        0:       row = row - 4'd1;
        1:       col = col + 4'd1;
        2:       row = row + 4'd1;
        default: col = col - 4'd1;
      endcase
      exp_loc = {row, col};
    end
    l.loc = exp_loc;
    sb.push_back(d);
    sb.push_back(l);
    WLL = w; CMPS = c; MTN_SENSOR = m;
    repeat (hold) @(negedge CLK);
    WLL = 4'd0;
    @(negedge CLK);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    if (sb.size() > 0) begin
      check_val("drain_timeout", sb.size(), 32'd0);
      sb.delete();
    end
  endtask

  task automatic start(input logic [7:0] loc);
    ONOFF = 2'b01; LCN_0 = loc;
    @(negedge CLK);
    ONOFF = 2'b00;
    exp_loc = loc;
    check_val("start_loc", {24'd0, LOCATION}, {24'd0, loc});
    check_val("start_drv", {31'd0, DRIVING}, 32'd0);
    check_val("start_act", {29'd0, ACTION}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [2:0] wb;
    logic [3:0] wr;
    logic [3:0] cr;
    logic [3:0] mr;
    RST_N = 1'b0; ONOFF = 2'b00; LCN_0 = 8'h00; MTN_SENSOR = 4'd0; CMPS = 4'b1000; WLL = 4'd0;
    repeat (3) @(negedge CLK);
    check_val("rst_turn", {30'd0, TURN}, 32'd0);
    check_val("rst_drv", {31'd0, DRIVING}, 32'd0);
    check_val("rst_loc", {24'd0, LOCATION}, 32'd0);
    check_val("rst_act", {29'd0, ACTION}, 32'd0);
    RST_N = 1'b1;
    @(negedge CLK);

    start(8'h60);
    issue(4'b0110, 4'b1000, 4'b0001, 1); drain();   // right -> 0x61
    issue(4'b0011, 4'b1000, 4'b0100, 1); drain();   // left  -> 0x60
    start(8'h05);
    issue(4'b0101, 4'b1000, 4'b1000, 1); drain();   // straight, row wraps -> 0xF5
    issue(4'b0111, 4'b0001, 4'b0000, 1); drain();   // U-turn from W -> E
    issue(4'b0110, 4'b1100, 4'b0010, 1); drain();   // compass fault, no move
    issue(4'b1001, 4'b0100, 4'b0010, 1); drain();   // WLL[3] ignored, straight E

    // Back-to-back strobes through the full pipeline.
    for (int i = 0; i < 10; i++) begin
      wb = 3'($urandom_range(1, 7));
      wr = {1'($urandom_range(0, 1)), wb};
      cr = (i == 6) ? 4'b0000 : 4'(4'b0001 << $urandom_range(0, 3));
      mr = 4'($urandom());
      issue(wr, cr, mr, 1);
    end
    drain();

    // Held walls must produce exactly one step.
    issue(4'b0101, 4'b0100, 4'b0000, 10); drain();
    repeat (4) @(negedge CLK);
    check_val("hold_single_step", {24'd0, LOCATION}, {24'd0, exp_loc});

    // Stop on the same edge as a strobe: stop wins.
    ONOFF = 2'b10; WLL = 4'b0110; CMPS = 4'b1000; MTN_SENSOR = 4'b0001;
    @(negedge CLK);
    ONOFF = 2'b00; WLL = 4'd0;
    repeat (2) @(negedge CLK);
    check_val("stop_drv", {31'd0, DRIVING}, 32'd0);
    check_val("stop_act", {29'd0, ACTION}, 32'd7);
    check_val("stop_turn", {30'd0, TURN}, 32'd0);
    check_val("stop_loc", {24'd0, LOCATION}, {24'd0, exp_loc});
    WLL = 4'b0110;
    @(negedge CLK);
    WLL = 4'd0;
    repeat (3) @(negedge CLK);
    check_val("off_ignore_act", {29'd0, ACTION}, 32'd7);
    check_val("off_ignore_drv", {31'd0, DRIVING}, 32'd0);
    check_val("off_ignore_loc", {24'd0, LOCATION}, {24'd0, exp_loc});

    start(8'h3A);
    issue(4'b0110, 4'b1000, 4'b0000, 1); drain();   // right from N -> 0x3B

    // Reset while a step is in flight discards it.
    WLL = 4'b0110; CMPS = 4'b1000; MTN_SENSOR = 4'b1000;
    @(negedge CLK);
    WLL = 4'd0; RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    check_val("midrst_turn", {30'd0, TURN}, 32'd0);
    check_val("midrst_drv", {31'd0, DRIVING}, 32'd0);
    check_val("midrst_act", {29'd0, ACTION}, 32'd0);
    check_val("midrst_loc", {24'd0, LOCATION}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
